// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and flag helpers for the pipelined ALU.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SHR = 3'd5;
   localparam logic [2:0] OP_SHL = 3'd6;
   localparam logic [2:0] OP_MUL = 3'd7;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_t;

   // Two's-complement overflow from the operand and result sign bits; for a
   // subtraction the B sign is inverted because a-b is a+(~b)+1.
   function automatic logic signedOverflow(input logic aMsb,
                                           input logic bMsb,
                                           input logic sMsb,
                                           input logic isSub);
      logic bEff;
      bEff = isSub ? ~bMsb : bMsb;
      return (aMsb == bEff) && (sMsb != aMsb);
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one WIDTH+1-bit add per clock,
// WIDTH clocks per product. done_o flags the edge that performs the last step,
// and product_o presents the accumulator value that step produces.
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   output logic                 done_o,
   output logic [2*WIDTH-1:0]   product_o
);

   logic [WIDTH-1:0]   multiplicand_q;
   logic [WIDTH-1:0]   multiplier_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_d;
   logic [CNT_W-1:0]   count_q;
   logic [WIDTH:0]     partialSum;

   // One shift-add step: add the multiplicand into the upper half when the
   // current multiplier bit is set, then shift the whole accumulator right.
   always_comb begin
      partialSum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (multiplier_q[0] ? {1'b0, multiplicand_q} : {(WIDTH+1){1'b0}});
      acc_d      = {partialSum, acc_q[WIDTH-1:1]};
   end

   // Load operands on start, otherwise step while iterations remain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         multiplicand_q <= '0;
         multiplier_q   <= '0;
         acc_q          <= '0;
         count_q        <= '0;
      end else if (start_i) begin
         multiplicand_q <= a_i;
         multiplier_q   <= b_i;
         acc_q          <= '0;
         count_q        <= CNT_W'(WIDTH);
      end else if (count_q != '0) begin
         acc_q          <= acc_d;
         multiplier_q   <= multiplier_q >> 1;
         count_q        <= count_q - 1'b1;
      end
   end

   assign done_o    = (count_q == CNT_W'(1));
   assign product_o = acc_d;

endmodule

// File: rtl/alu_pipe_hs.sv
// Registered ALU with valid/ready handshakes on both sides. Single-cycle ops
// give one result per clock; MUL is handed to the iterative multiplier and the
// input side is held off until its product lands in the output registers.
module alu_pipe_hs
   import alu_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] s_hi,
   output logic             co,
   output logic             zf,
   output logic             ovf,
   output logic             busy
);

   state_t             state_q;
   logic               outValid_q;
   logic [WIDTH-1:0]   s_q;
   logic [WIDTH-1:0]   sHi_q;
   logic               co_q;
   logic               zf_q;
   logic               ovf_q;
   logic               busy_q;

   logic [WIDTH:0]     addFull;
   logic [WIDTH:0]     subFull;
   logic [WIDTH-1:0]   opS;
   logic               opCo;
   logic               opZf;
   logic               opOvf;
   logic               opIsMul;
   logic               opKnown;

   logic               accept;
   logic               mulStart;
   logic               mulDone;
   logic [2*WIDTH-1:0] mulProduct;

   // Input handshake: only idle, and only when the output slot is free or
   // being emptied on this same edge.
   always_comb begin
      in_ready = (state_q == IDLE) && (!outValid_q || out_ready);
      accept   = in_valid && in_ready;
      mulStart = accept && opIsMul;
   end

   // Single-cycle datapath; an undecodable opcode yields zero result and flags.
   always_comb begin
      addFull = {1'b0, a} + {1'b0, b};
      subFull = {1'b0, a} - {1'b0, b};
      opS     = '0;
      opCo    = 1'b0;
      opOvf   = 1'b0;
      opIsMul = 1'b0;
      opKnown = 1'b0;
      case (sel)
         OP_ADD: begin
            opS     = addFull[WIDTH-1:0];
            opCo    = addFull[WIDTH];
            opOvf   = signedOverflow(a[WIDTH-1], b[WIDTH-1], addFull[WIDTH-1], 1'b0);
            opKnown = 1'b1;
         end
         OP_SUB: begin
            opS     = subFull[WIDTH-1:0];
            opCo    = subFull[WIDTH];
            opOvf   = signedOverflow(a[WIDTH-1], b[WIDTH-1], subFull[WIDTH-1], 1'b1);
            opKnown = 1'b1;
         end
         OP_AND: begin
            opS     = a & b;
            opKnown = 1'b1;
         end
         OP_OR: begin
            opS     = a | b;
            opKnown = 1'b1;
         end
         OP_XOR: begin
            opS     = a ^ b;
            opKnown = 1'b1;
         end
         OP_SHR: begin
            opS     = a >> 1;
            opCo    = a[0];
            opKnown = 1'b1;
         end
         OP_SHL: begin
            opS     = a << 1;
            opCo    = a[WIDTH-1];
            opKnown = 1'b1;
         end
         OP_MUL: begin
            opIsMul = 1'b1;
         end
         default: begin
            opKnown = 1'b0;
         end
      endcase
      opZf = opKnown && (opS == '0);
   end

   alu_mul_iter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (mulStart),
      .a_i       (a),
      .b_i       (b),
      .done_o    (mulDone),
      .product_o (mulProduct)
   );

   // Control FSM and output registers: single-cycle results land at the
   // accepting edge, multiply results at the multiplier's final step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         outValid_q <= 1'b0;
         s_q        <= '0;
         sHi_q      <= '0;
         co_q       <= 1'b0;
         zf_q       <= 1'b0;
         ovf_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (opIsMul) begin
                     state_q    <= MUL;
                     busy_q     <= 1'b1;
                     outValid_q <= 1'b0;
                  end else begin
                     outValid_q <= 1'b1;
                     s_q        <= opS;
                     sHi_q      <= '0;
                     co_q       <= opCo;
                     zf_q       <= opZf;
                     ovf_q      <= opOvf;
                  end
               end else if (out_ready) begin
                  outValid_q <= 1'b0;
               end
            end
            MUL: begin
               if (mulDone) begin
                  state_q    <= IDLE;
                  busy_q     <= 1'b0;
                  outValid_q <= 1'b1;
                  s_q        <= mulProduct[WIDTH-1:0];
                  sHi_q      <= mulProduct[2*WIDTH-1:WIDTH];
                  co_q       <= |mulProduct[2*WIDTH-1:WIDTH];
                  zf_q       <= (mulProduct == '0);
                  ovf_q      <= 1'b0;
               end
            end
         endcase
      end
   end

   assign out_valid = outValid_q;
   assign s         = s_q;
   assign s_hi      = sHi_q;
   assign co        = co_q;
   assign zf        = zf_q;
   assign ovf       = ovf_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_alu_pipe_hs.sv
// Directed bench for alu_pipe_hs at WIDTH=4: a streamed table of single-cycle
// vectors, then hand-written multiply, backpressure and reset-abort sequences.
module tb_alu_pipe_hs;
   import alu_pkg::*;

   localparam int W  = 4;
   localparam int NV = 25;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [2:0]   sel;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] s;
   logic [W-1:0] s_hi;
   logic         co;
   logic         zf;
   logic         ovf;
   logic         busy;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [2:0]   sel;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] expS;
      logic         expCo;
      logic         expZf;
      logic         expOvf;
   } vec_t;

   vec_t vecs [NV];

   alu_pipe_hs #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .s_hi      (s_hi),
      .co        (co),
      .zf        (zf),
      .ovf       (ovf),
      .busy      (busy)
   );

   // Free-running 10 ns clock; rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] opA,
                                input logic [W-1:0] opB, input logic valid);
      sel      = op;
      a        = opA;
      b        = opB;
      in_valid = valid;
   endtask

   task automatic checkVector(input int idx);
      checkOutput($sformatf("v%0d.out_valid", idx), 4'(out_valid), 4'h1);
      checkOutput($sformatf("v%0d.s", idx), s, vecs[idx].expS);
      checkOutput($sformatf("v%0d.s_hi", idx), s_hi, 4'h0);
      checkOutput($sformatf("v%0d.co", idx), 4'(co), 4'(vecs[idx].expCo));
      checkOutput($sformatf("v%0d.zf", idx), 4'(zf), 4'(vecs[idx].expZf));
      checkOutput($sformatf("v%0d.ovf", idx), 4'(ovf), 4'(vecs[idx].expOvf));
   endtask

   task automatic mulSeq(input logic [W-1:0] opA, input logic [W-1:0] opB,
                         input logic [W-1:0] expS, input logic [W-1:0] expHi,
                         input logic expCo, input logic expZf);
      @(negedge clk);
      out_ready = 1'b1;
      checkOutput("mul.in_ready_before", 4'(in_ready), 4'h1);
      applyStimulus(OP_MUL, opA, opB, 1'b1);
      @(negedge clk);
      applyStimulus(OP_ADD, 4'h1, 4'h1, 1'b1);
      for (int k = 0; k < W; k++) begin
         if (k > 0) @(negedge clk);
         checkOutput($sformatf("mul.busy%0d", k), 4'(busy), 4'h1);
         checkOutput($sformatf("mul.in_ready%0d", k), 4'(in_ready), 4'h0);
         checkOutput($sformatf("mul.out_valid%0d", k), 4'(out_valid), 4'h0);
      end
      @(negedge clk);
      checkOutput("mul.out_valid", 4'(out_valid), 4'h1);
      checkOutput("mul.busy_done", 4'(busy), 4'h0);
      checkOutput("mul.s", s, expS);
      checkOutput("mul.s_hi", s_hi, expHi);
      checkOutput("mul.co", 4'(co), 4'(expCo));
      checkOutput("mul.zf", 4'(zf), 4'(expZf));
      checkOutput("mul.ovf", 4'(ovf), 4'h0);
      applyStimulus(OP_ADD, 4'h0, 4'h0, 1'b0);
      @(negedge clk);
      checkOutput("mul.consumed", 4'(out_valid), 4'h0);
   endtask

   initial begin
      vecs[0]  = '{3'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{3'd1, 4'h1, 4'h1, 4'h0, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{3'd2, 4'h2, 4'h2, 4'h2, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{3'd3, 4'h3, 4'h3, 4'h3, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{3'd4, 4'h4, 4'h4, 4'h0, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{3'd5, 4'h5, 4'h5, 4'h2, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{3'd6, 4'h6, 4'h6, 4'hC, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{3'd0, 4'h7, 4'h7, 4'hE, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{3'd1, 4'h8, 4'h8, 4'h0, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{3'd2, 4'h9, 4'h9, 4'h9, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{3'd3, 4'hA, 4'hA, 4'hA, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{3'd4, 4'hB, 4'hB, 4'h0, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{3'd5, 4'hC, 4'hC, 4'h6, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{3'd6, 4'hD, 4'hD, 4'hA, 1'b1, 1'b0, 1'b0};
      vecs[14] = '{3'd0, 4'hE, 4'hE, 4'hC, 1'b1, 1'b0, 1'b0};
      vecs[15] = '{3'd1, 4'hF, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0};
      vecs[16] = '{3'd0, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1, 1'b0};
      vecs[17] = '{3'd1, 4'h7, 4'h8, 4'hF, 1'b1, 1'b0, 1'b1};
      vecs[18] = '{3'd6, 4'h9, 4'h0, 4'h2, 1'b1, 1'b0, 1'b0};
      vecs[19] = '{3'd0, 4'h7, 4'h1, 4'h8, 1'b0, 1'b0, 1'b1};
      vecs[20] = '{3'd1, 4'h8, 4'h1, 4'h7, 1'b0, 1'b0, 1'b1};
      vecs[21] = '{3'd4, 4'hA, 4'h6, 4'hC, 1'b0, 1'b0, 1'b0};
      vecs[22] = '{3'd5, 4'h9, 4'h0, 4'h4, 1'b1, 1'b0, 1'b0};
      vecs[23] = '{3'd3, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
      vecs[24] = '{3'd1, 4'h3, 4'h5, 4'hE, 1'b1, 1'b0, 1'b0};

      rst_n     = 1'b0;
      out_ready = 1'b0;
      applyStimulus(OP_ADD, 4'h0, 4'h0, 1'b0);

      repeat (2) @(negedge clk);
      checkOutput("rst.out_valid", 4'(out_valid), 4'h0);
      checkOutput("rst.s", s, 4'h0);
      checkOutput("rst.s_hi", s_hi, 4'h0);
      checkOutput("rst.flags", {1'b0, co, zf, ovf}, 4'h0);
      checkOutput("rst.busy", 4'(busy), 4'h0);
      checkOutput("rst.in_ready", 4'(in_ready), 4'h1);
      rst_n = 1'b1;

      $display("[TB] streaming %0d single-cycle vectors", NV);
      out_ready = 1'b1;
      for (int i = 0; i <= NV; i++) begin
         @(negedge clk);
         if (i > 0) checkVector(i - 1);
         if (i < NV) begin
            checkOutput($sformatf("v%0d.in_ready", i), 4'(in_ready), 4'h1);
            applyStimulus(vecs[i].sel, vecs[i].a, vecs[i].b, 1'b1);
         end else begin
            applyStimulus(OP_ADD, 4'h0, 4'h0, 1'b0);
         end
      end
      @(negedge clk);
      checkOutput("stream.drained", 4'(out_valid), 4'h0);

      $display("[TB] multiply sequences");
      mulSeq(4'hF, 4'hF, 4'h1, 4'hE, 1'b1, 1'b0);
      mulSeq(4'hD, 4'h6, 4'hE, 4'h4, 1'b1, 1'b0);
      mulSeq(4'h2, 4'h8, 4'h0, 4'h1, 1'b1, 1'b0);
      mulSeq(4'h0, 4'h5, 4'h0, 4'h0, 1'b0, 1'b1);

      $display("[TB] backpressure");
      @(negedge clk);
      out_ready = 1'b0;
      applyStimulus(OP_ADD, 4'h3, 4'h4, 1'b1);
      @(negedge clk);
      applyStimulus(OP_XOR, 4'h5, 4'h3, 1'b1);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         checkOutput($sformatf("bp.out_valid%0d", k), 4'(out_valid), 4'h1);
         checkOutput($sformatf("bp.s%0d", k), s, 4'h7);
         checkOutput($sformatf("bp.in_ready%0d", k), 4'(in_ready), 4'h0);
      end
      out_ready = 1'b1;
      #1;
      checkOutput("bp.in_ready_release", 4'(in_ready), 4'h1);
      @(negedge clk);
      checkOutput("bp.next_valid", 4'(out_valid), 4'h1);
      checkOutput("bp.next_s", s, 4'h6);
      checkOutput("bp.next_flags", {1'b0, co, zf, ovf}, 4'h0);
      applyStimulus(OP_ADD, 4'h0, 4'h0, 1'b0);
      @(negedge clk);
      checkOutput("bp.drained", 4'(out_valid), 4'h0);

      $display("[TB] reset during multiply");
      @(negedge clk);
      applyStimulus(OP_MUL, 4'h7, 4'h3, 1'b1);
      @(negedge clk);
      applyStimulus(OP_ADD, 4'h0, 4'h0, 1'b0);
      checkOutput("rmul.busy", 4'(busy), 4'h1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("rmul.out_valid", 4'(out_valid), 4'h0);
      checkOutput("rmul.busy_cleared", 4'(busy), 4'h0);
      checkOutput("rmul.s", s, 4'h0);
      checkOutput("rmul.s_hi", s_hi, 4'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("rmul.in_ready", 4'(in_ready), 4'h1);
      applyStimulus(OP_ADD, 4'h1, 4'h1, 1'b1);
      @(negedge clk);
      checkOutput("rmul.add_valid", 4'(out_valid), 4'h1);
      checkOutput("rmul.add_s", s, 4'h2);
      checkOutput("rmul.add_flags", {1'b0, co, zf, ovf}, 4'h0);
      applyStimulus(OP_ADD, 4'h0, 4'h0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checkOutput($sformatf("rmul.quiet%0d", k), 4'(out_valid), 4'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
